mips_store_buffer: RTL and testbench

Word-granular posted-write buffer between `mips_cpu_harvard`'s data port and the single-port data RAM. It absorbs CPU stores in one cycle and drains them to RAM whenever the RAM port is not serving a CPU load. It forwards buffered data to loads that hit a pending store. It stalls the CPU through the clock-enable path only when full, so the CPU's combinational-read / single-cycle-write contract is preserved.

---
 rtl/mips_store_buffer.sv | 110 +++++++++++
 tb/tb_mips_store_buffer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_store_buffer.sv
// Posted-write buffer between the CPU data port and single-port data RAM, with load forwarding.
// Optional in-place store merging is enabled by defining STORE_BUFFER_COALESCE_EN.
module mips_store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  output logic        cpu_clk_enable,
  input  logic [31:0] data_address,
  input  logic        data_write,
  input  logic        data_read,
  input  logic [31:0] data_writedata,
  output logic [31:0] data_readdata,
  output logic [31:0] mem_address,
  output logic        mem_write,
  output logic        mem_read,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  output logic        buf_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic        full;
  logic        any_match;
  logic [31:0] fwd_data;
  logic        load_miss;
  logic        drain;
  logic        accept;
  logic        coalesce;
`ifdef STORE_BUFFER_COALESCE_EN
  logic [PW-1:0] match_idx;
`endif

  assign full           = (count == CW'(DEPTH));
  assign buf_empty      = (count == '0);
  assign cpu_clk_enable = clk_enable & ~full;

  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    any_match = 1'b0;
    fwd_data  = '0;
`ifdef STORE_BUFFER_COALESCE_EN
    match_idx = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < count && addr_q[head + PW'(k)][31:2] == data_address[31:2]) begin
        any_match = 1'b1;
        fwd_data  = data_q[head + PW'(k)];
`ifdef STORE_BUFFER_COALESCE_EN
        match_idx = head + PW'(k);
`endif
      end
    end
  end

  // A store presented alongside a load wins, so it never counts as a miss.
  assign load_miss = data_read & ~data_write & ~any_match;
  assign drain     = (count != '0) & (~load_miss | full);

  assign mem_write     = drain;
  assign mem_read      = load_miss & ~drain;
  assign mem_address   = drain ? addr_q[head] : data_address;
  assign mem_writedata = data_q[head];
  assign data_readdata = (data_read & any_match) ? fwd_data : mem_readdata;

`ifdef STORE_BUFFER_COALESCE_EN
  // Merging into the head while it drains would lose the new data; allocate instead.
  assign coalesce = data_write & clk_enable & any_match & ~(match_idx == head & drain);
  assign accept   = data_write & cpu_clk_enable & ~coalesce;
`else
  assign coalesce = 1'b0;
  assign accept   = data_write & cpu_clk_enable;
`endif

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q[tail] <= data_address;
      data_q[tail] <= data_writedata;
    end
`ifdef STORE_BUFFER_COALESCE_EN
    if (coalesce) data_q[match_idx] <= data_writedata;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (accept) tail <= tail + PW'(1);
      if (drain)  head <= head + PW'(1);
      case ({accept, drain})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_store_buffer.sv
// Randomized and directed bench for mips_store_buffer against a queue-based reference model.
// The RAM is modelled here; final RAM contents are compared with the model's expected memory.
module tb_mips_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_enable;
  logic        cpu_clk_enable;
  logic [31:0] data_address;
  logic        data_write;
  logic        data_read;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;
  logic [31:0] mem_address;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        buf_empty;

  mips_store_buffer #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .clk_enable     (clk_enable),
    .cpu_clk_enable (cpu_clk_enable),
    .data_address   (data_address),
    .data_write     (data_write),
    .data_read      (data_read),
    .data_writedata (data_writedata),
    .data_readdata  (data_readdata),
    .mem_address    (mem_address),
    .mem_write      (mem_write),
    .mem_read       (mem_read),
    .mem_writedata  (mem_writedata),
    .mem_readdata   (mem_readdata),
    .buf_empty      (buf_empty)
  );

  always #5 clk = ~clk;

  // RAM: 512 words covering byte addresses 0x000..0x7FF.
  logic [31:0] ram [512];
  logic        ram_init;

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 512; i++) ram[i] <= 32'hD000_0000 | i;
    end else if (!reset && mem_write) begin
      ram[mem_address[10:2]] <= mem_writedata;
    end
  end

  assign mem_readdata = ram[mem_address[10:2]];

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  logic [31:0] ref_mem [512];
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // One CPU cycle: drive at negedge, check combinational outputs, then advance model at posedge.
  task automatic step(input logic w, input logic r, input logic [31:0] a,
                      input logic [31:0] d, input logic ce);
    logic        hit, miss, drn, fullm, ecen;
    logic [31:0] fwd;
    int          hi, ci;
    data_write = w; data_read = r; data_address = a; data_writedata = d; clk_enable = ce;
    #1;
    fullm = (q.size() == DEPTH);
    ecen  = ce && !fullm;
    hit = 1'b0; hi = -1; fwd = '0;
    for (int i = 0; i < q.size(); i++) begin
      if (q[i].a[31:2] == a[31:2]) begin hit = 1'b1; hi = i; fwd = q[i].d; end
    end
    miss = r && !w && !hit;
    drn  = (q.size() > 0) && (!miss || fullm);
    check("cpu_clk_enable", {31'b0, cpu_clk_enable}, {31'b0, ecen});
    check("buf_empty", {31'b0, buf_empty}, {31'b0, q.size() == 0});
    check("mem_write", {31'b0, mem_write}, {31'b0, drn});
    check("mem_read", {31'b0, mem_read}, {31'b0, miss && !drn});
    if (drn) begin
      check("mem_address_drain", mem_address, q[0].a);
      check("mem_writedata", mem_writedata, q[0].d);
    end else begin
      check("mem_address", mem_address, a);
    end
    if (r && !w && hit)
      check("fwd_data", data_readdata, fwd);
    else if (miss && !drn)
      check("miss_data", data_readdata, ref_mem[a[10:2]]);
    @(posedge clk);
    ci = -1;
`ifdef STORE_BUFFER_COALESCE_EN
    if (w && ce && hit && !(hi == 0 && drn)) ci = hi;
`endif
    if (ci >= 0) q[ci].d = d;
    if (drn) begin
      ref_mem[q[0].a[10:2]] = q[0].d;
      void'(q.pop_front());
    end
    if (w && ecen && ci < 0) q.push_back('{a, d});
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0000_0700, 32'h0, 1'b1);
  endtask

  function automatic logic [31:0] rand_addr();
    return 32'h100 + 4 * $urandom_range(0, 7) + $urandom_range(0, 3);
  endfunction

  initial begin
    logic w, r, ce;
    reset = 1'b1; ram_init = 1'b1;
    clk_enable = 1'b1; data_write = 1'b0; data_read = 1'b0;
    data_address = '0; data_writedata = '0;
    for (int i = 0; i < 512; i++) ref_mem[i] = 32'hD000_0000 | i;
    @(negedge clk); @(negedge clk);
    ram_init = 1'b0;
    reset = 1'b0;

    // Reset state, then a single store drained the following cycle.
    idle();
    step(1'b1, 1'b0, 32'h100, 32'h1234_5678, 1'b1);
    idle();
    idle();

    // Forwarding of the youngest store to the same word.
    step(1'b1, 1'b0, 32'h104, 32'hAAAA_0001, 1'b1);
    step(1'b1, 1'b0, 32'h104, 32'hAAAA_0002, 1'b1);
    step(1'b0, 1'b1, 32'h106, 32'h0, 1'b1);
    step(1'b0, 1'b1, 32'h500, 32'h0, 1'b1);
    idle();

    // Back-to-back stores with interleaved load misses.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 32'h200 + 4 * i, 32'hB000_0000 + i, 1'b1);
      step(1'b0, 1'b1, 32'h580, 32'h0, 1'b1);
    end
    idle(); idle();

    // Load miss while 0x100 is pending: port goes to the load, no drain.
    step(1'b1, 1'b0, 32'h100, 32'hC0DE_0100, 1'b1);
    step(1'b0, 1'b1, 32'h300, 32'h0, 1'b1);
    step(1'b0, 1'b1, 32'h100, 32'h0, 1'b1);
    idle();

    // Repeated stores to one word.
    step(1'b1, 1'b0, 32'h400, 32'd1, 1'b1);
    step(1'b1, 1'b0, 32'h400, 32'd2, 1'b1);
    step(1'b1, 1'b0, 32'h400, 32'd3, 1'b1);
    idle(); idle();

    // CPU held off by the bench: nothing accepted.
    step(1'b1, 1'b0, 32'h408, 32'hDEAD_BEEF, 1'b0);
    idle();

    // Reset asserted while a store is draining.
    step(1'b1, 1'b0, 32'h600, 32'h6666_6666, 1'b1);
    step(1'b0, 1'b1, 32'h604, 32'h0, 1'b1);
    data_write = 1'b0; data_read = 1'b0; data_address = 32'h700; clk_enable = 1'b1;
    #1;
    check("pre_reset_mem_write", {31'b0, mem_write}, 32'd1);
    reset = 1'b1;
    #1;
    check("reset_mem_write", {31'b0, mem_write}, 32'd0);
    check("reset_buf_empty", {31'b0, buf_empty}, 32'd1);
    check("reset_cpu_clk_enable", {31'b0, cpu_clk_enable}, 32'd1);
    q.delete();
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    idle();

    // Randomized traffic.
    for (int n = 0; n < 2000; n++) begin
      w  = ($urandom % 10) < 4;
      r  = ($urandom % 10) < 4;
      if (w && r && ($urandom % 8) != 0) r = 1'b0;
      ce = ($urandom % 10) < 8;
      step(w, r, rand_addr(), $urandom, ce);
    end

    // Drain and compare RAM.
    for (int n = 0; n < 50 && q.size() > 0; n++) idle();
    check("final_queue_empty", q.size(), 0);
    idle();
    for (int i = 0; i < 512; i++) check("ram_word", ram[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
